// File: rtl/cam_frame_capture_pkg.sv
// Shared encodings for the camera frame-capture block: FSM states, pixel-format
// modes and the RGB565 red/blue swap helper.
package cam_frame_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_CAP  = 2'd2,
        ST_DONE = 2'd3
    } cap_state_t;

    localparam logic [1:0] MODE_RGB  = 2'd0;
    localparam logic [1:0] MODE_SWAP = 2'd1;
    localparam logic [1:0] MODE_BIN  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    function automatic logic [15:0] rb_swap(input logic [15:0] p);
        return {p[4:0], p[10:5], p[15:11]};
    endfunction

endpackage

// File: rtl/cam_pixel_packer.sv
// Pairs camera bytes into RGB565 pixels, applies the pixel format and packs
// pixels into 32-bit words; emits a registered word strobe and flushes partial words.
module cam_pixel_packer
    import cam_frame_capture_pkg::*;
(
    input  logic        PCLK,
    input  logic        HRESETn,
    input  logic        cap_en,
    input  logic        flush,
    input  logic [1:0]  mode,
    input  logic [5:0]  thresh,
    input  logic [7:0]  cam_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic        phase;
    logic [7:0]  hi_byte;
    logic [4:0]  cnt;
    logic [31:0] sr;

    logic [1:0]  mode_eff;
    logic [15:0] pixel;
    logic [15:0] pixel_fmt;
    logic        pix_bit;

    always_comb begin
        mode_eff  = (mode == MODE_RSVD) ? MODE_RGB : mode;
        pixel     = {hi_byte, cam_data};
        pixel_fmt = (mode_eff == MODE_SWAP) ? rb_swap(pixel) : pixel;
        pix_bit   = (pixel[10:5] >= thresh);
    end

    // sr is kept zero outside the filled positions so a flush is already zero-padded.
    always_ff @(posedge PCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            phase      <= 1'b0;
            hi_byte    <= 8'h00;
            cnt        <= 5'd0;
            sr         <= 32'h0;
            word_valid <= 1'b0;
            word_data  <= 32'h0;
        end else begin
            word_valid <= 1'b0;
            if (!cap_en) begin
                phase <= 1'b0;
                cnt   <= 5'd0;
                sr    <= 32'h0;
                if (flush && (cnt != 5'd0)) begin
                    word_valid <= 1'b1;
                    word_data  <= sr;
                end
            end else if (!phase) begin
                hi_byte <= cam_data;
                phase   <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (mode_eff == MODE_BIN) begin
                    if (cnt == 5'd31) begin
                        word_valid <= 1'b1;
                        word_data  <= {pix_bit, sr[30:0]};
                        sr         <= 32'h0;
                        cnt        <= 5'd0;
                    end else begin
                        sr[cnt] <= pix_bit;
                        cnt     <= cnt + 5'd1;
                    end
                end else begin
                    if (cnt == 5'd0) begin
                        sr[15:0] <= pixel_fmt;
                        cnt      <= 5'd1;
                    end else begin
                        word_valid <= 1'b1;
                        word_data  <= {pixel_fmt, sr[15:0]};
                        sr         <= 32'h0;
                        cnt        <= 5'd0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cam_frame_capture.sv
// Camera frame capture: request synchroniser, frame FSM and frame-buffer addressing.
// state | meaning
// IDLE  | waiting for a synchronised request while VSYNC is high
// ARM   | request seen; waiting for VSYNC low to start the frame
// CAP   | capturing lines into the frame buffer
// DONE  | frame complete; waiting for the request to drop
module cam_frame_capture
    import cam_frame_capture_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              HRESETn,
    input  logic              cap_req,
    input  logic [1:0]        mode,
    input  logic [5:0]        thresh,
    input  logic [7:0]        cam_data,
    input  logic              VSYNC,
    input  logic              HREF,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              done,
    output logic              busy,
    output logic              ovf,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   vs_s;
    logic                   href_q;
    cap_state_t             state;
    cap_state_t             state_nx;
    logic [1:0]             mode_l;
    logic [5:0]             thresh_l;
    logic                   cap_en;
    logic                   line_end;
    logic                   start;
    logic                   pk_valid;
    logic [31:0]            pk_data;

    assign req_s = req_sync[SYNC_STAGES-1];

    always_ff @(posedge PCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            req_sync <= '0;
            vs_s     <= 1'b0;
            href_q   <= 1'b0;
        end else begin
            req_sync[0] <= cap_req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                req_sync[i] <= req_sync[i-1];
            end
            vs_s   <= VSYNC;
            href_q <= HREF;
        end
    end

    always_ff @(posedge PCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req_s && vs_s) state_nx = ST_ARM;
            ST_ARM:  if (!req_s) state_nx = ST_IDLE;
                     else if (!vs_s) state_nx = ST_CAP;
            ST_CAP:  if (!req_s) state_nx = ST_IDLE;
                     else if (vs_s) state_nx = ST_DONE;
            ST_DONE: if (!req_s) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Writes are only let through while capturing, so an abort cannot leak a word.
    always_comb begin
        done     = (state == ST_DONE);
        busy     = (state == ST_ARM) || (state == ST_CAP);
        cap_en   = (state == ST_CAP) && HREF && !VSYNC;
        line_end = (state == ST_CAP) && href_q && !HREF;
        start    = (state == ST_IDLE) && (state_nx == ST_ARM);
        wr_en    = pk_valid && (state == ST_CAP) && !word_cnt[ADDR_W];
    end

    always_ff @(posedge PCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_addr  <= '0;
            word_cnt <= '0;
            ovf      <= 1'b0;
            mode_l   <= MODE_RGB;
            thresh_l <= 6'd0;
        end else if (start) begin
            wr_addr  <= '0;
            word_cnt <= '0;
            ovf      <= 1'b0;
            mode_l   <= mode;
            thresh_l <= thresh;
        end else if (pk_valid && (state == ST_CAP)) begin
            if (word_cnt[ADDR_W]) begin
                ovf <= 1'b1;
            end else begin
                word_cnt <= word_cnt + CNT_ONE;
                if (wr_addr != '1) begin
                    wr_addr <= wr_addr + ADDR_ONE;
                end
            end
        end
    end

    cam_pixel_packer u_packer (
        .PCLK       (PCLK),
        .HRESETn    (HRESETn),
        .cap_en     (cap_en),
        .flush      (line_end),
        .mode       (mode_l),
        .thresh     (thresh_l),
        .cam_data   (cam_data),
        .word_valid (pk_valid),
        .word_data  (pk_data)
    );

    assign wr_data = pk_data;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture: a scoreboard queue of expected writes is
// filled as pixels are driven and drained by write monitors on both DUT instances.
module tb_cam_frame_capture;

    logic        PCLK     = 1'b0;
    logic        HRESETn  = 1'b0;
    logic        cap_req  = 1'b0;
    logic        cap_req_s = 1'b0;
    logic [1:0]  mode     = 2'd0;
    logic [5:0]  thresh   = 6'd0;
    logic [7:0]  cam_data = 8'h00;
    logic        VSYNC    = 1'b1;
    logic        HREF     = 1'b0;

    logic        wr_en, done, busy, ovf;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [16:0] word_cnt;

    logic        wr_en_s, done_s, busy_s, ovf_s;
    logic [3:0]  wr_addr_s;
    logic [31:0] wr_data_s;
    logic [4:0]  word_cnt_s;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [47:0] exp_q[$];
    logic [35:0] exp_q_s[$];
    logic [31:0] got_q[$];
    logic [15:0] pix[0:127];
    logic [1:0]  cur_mode;
    logic [5:0]  cur_thresh;
    int          exp_cnt   = 0;
    int          exp_cnt_s = 0;
    logic [3:0]  last_addr_s = 4'h0;

    always #5 PCLK = ~PCLK;

    cam_frame_capture dut (
        .PCLK(PCLK), .HRESETn(HRESETn), .cap_req(cap_req), .mode(mode), .thresh(thresh),
        .cam_data(cam_data), .VSYNC(VSYNC), .HREF(HREF), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .done(done), .busy(busy), .ovf(ovf), .word_cnt(word_cnt)
    );

    cam_frame_capture #(.ADDR_W(4), .SYNC_STAGES(2)) dut_s (
        .PCLK(PCLK), .HRESETn(HRESETn), .cap_req(cap_req_s), .mode(mode), .thresh(thresh),
        .cam_data(cam_data), .VSYNC(VSYNC), .HREF(HREF), .wr_en(wr_en_s), .wr_addr(wr_addr_s),
        .wr_data(wr_data_s), .done(done_s), .busy(busy_s), .ovf(ovf_s), .word_cnt(word_cnt_s)
    );

    always @(negedge PCLK) begin : mon_big
        logic [47:0] e;
        if (wr_en === 1'b1) begin
            got_q.push_back(wr_data);
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL wr_unexpected: observed addr %0h data %0h, expected no write", wr_addr, wr_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_assert++;
                assert ({wr_addr, wr_data} === e) else begin
                    n_fail++;
                    $error("FAIL wr_word: observed %0h/%0h expected %0h/%0h", wr_addr, wr_data, e[47:32], e[31:0]);
                end
            end
        end
    end

    always @(negedge PCLK) begin : mon_small
        logic [35:0] e;
        if (wr_en_s === 1'b1) begin
            last_addr_s = wr_addr_s;
            n_assert++;
            assert (exp_q_s.size() > 0) else begin
                n_fail++;
                $error("FAIL wr_s_unexpected: observed addr %0h data %0h, expected no write", wr_addr_s, wr_data_s);
            end
            if (exp_q_s.size() > 0) begin
                e = exp_q_s.pop_front();
                n_assert++;
                assert ({wr_addr_s, wr_data_s} === e) else begin
                    n_fail++;
                    $error("FAIL wr_s_word: observed %0h/%0h expected %0h/%0h", wr_addr_s, wr_data_s, e[35:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    // sel: 0 = default instance, 1 = ADDR_W=4 instance, 2 = no capture expected
    task automatic push_word(input int sel, input logic [31:0] d);
        if (sel == 0) begin
            exp_q.push_back({exp_cnt[15:0], d});
            exp_cnt++;
        end else if (sel == 1) begin
            if (exp_cnt_s < 16) begin
                exp_q_s.push_back({exp_cnt_s[3:0], d});
                exp_cnt_s++;
            end
        end
    endtask

    task automatic drive_pixel(input logic [15:0] p);
        @(negedge PCLK);
        HREF = 1'b1;
        cam_data = p[15:8];
        @(negedge PCLK);
        cam_data = p[7:0];
    endtask

    task automatic start_frame(input int sel, input logic [1:0] m, input logic [5:0] t);
        mode = m;
        thresh = t;
        cur_mode = m;
        cur_thresh = t;
        exp_cnt = 0;
        exp_cnt_s = 0;
        got_q.delete();
        if (sel == 0) cap_req = 1'b1;
        else cap_req_s = 1'b1;
        VSYNC = 1'b1;
        cyc(5);
        VSYNC = 1'b0;
        cyc(3);
    endtask

    task automatic send_line(input int sel, input int n, input bit trailing);
        logic [31:0] acc;
        logic [15:0] p, pv;
        int k;
        acc = 32'h0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            p = pix[i];
            drive_pixel(p);
            if (cur_mode == 2'd2) begin
                acc[k] = (p[10:5] >= cur_thresh);
                k++;
                if (k == 32) begin
                    push_word(sel, acc);
                    acc = 32'h0;
                    k = 0;
                end
            end else begin
                pv = (cur_mode == 2'd1) ? {p[4:0], p[10:5], p[15:11]} : p;
                if (k == 0) begin
                    acc[15:0] = pv;
                    k = 1;
                end else begin
                    acc[31:16] = pv;
                    push_word(sel, acc);
                    acc = 32'h0;
                    k = 0;
                end
            end
        end
        if (trailing) begin
            @(negedge PCLK);
            cam_data = 8'hEE;
        end
        @(negedge PCLK);
        HREF = 1'b0;
        cam_data = 8'h00;
        if (k != 0) push_word(sel, acc);
        cyc(4);
    endtask

    task automatic end_frame();
        @(negedge PCLK);
        VSYNC = 1'b1;
        cyc(4);
    endtask

    initial begin
        // reset state
        cyc(3);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        HRESETn = 1'b1;
        cyc(2);

        // mode 0: two lines of four pixels
        start_frame(0, 2'd0, 6'd0);
        check("m0_busy", busy, 1);
        pix[0] = 16'h1234; pix[1] = 16'hABCD; pix[2] = 16'h5678; pix[3] = 16'h9ABC;
        send_line(0, 4, 1'b0);
        pix[0] = 16'h0F0F; pix[1] = 16'hF0F0; pix[2] = 16'h1111; pix[3] = 16'h2222;
        send_line(0, 4, 1'b0);
        end_frame();
        check("m0_done", done, 1);
        check("m0_word_cnt", word_cnt, 4);
        check("m0_first_word", got_q.size() > 0 ? got_q[0] : 32'hx, 32'hABCD1234);
        check("m0_q_empty", exp_q.size(), 0);
        cap_req = 1'b0;
        cyc(4);
        check("m0_idle_done", done, 0);

        // mode 1 with mid-frame mode change (must stay latched), flush and odd trailing byte
        start_frame(0, 2'd1, 6'd0);
        mode = 2'd0;
        pix[0] = 16'hF800; pix[1] = 16'h07E0; pix[2] = 16'h001F;
        send_line(0, 3, 1'b1);
        end_frame();
        check("m1_first_pixel", got_q.size() > 0 ? got_q[0][15:0] : 16'hx, 16'h001F);
        check("m1_word_cnt", word_cnt, 2);
        check("m1_q_empty", exp_q.size(), 0);
        cap_req = 1'b0;
        cyc(4);

        // mode 2: 40 alternating pixels, then a threshold-boundary line
        start_frame(0, 2'd2, 6'd32);
        for (int i = 0; i < 40; i++) pix[i] = (i % 2 == 0) ? 16'h07E0 : 16'h0000;
        send_line(0, 40, 1'b0);
        check("m2_word_cnt", word_cnt, 2);
        check("m2_word0", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h55555555);
        check("m2_flush", got_q.size() > 1 ? got_q[1] : 32'hx, 32'h00000055);
        pix[0] = 16'h03E0; pix[1] = 16'h0400;
        send_line(0, 2, 1'b0);
        end_frame();
        check("m2_word_cnt_end", word_cnt, 3);
        check("m2_q_empty", exp_q.size(), 0);
        cap_req = 1'b0;
        cyc(4);

        // overflow on the ADDR_W=4 instance: 40 words offered, 16 stored
        start_frame(1, 2'd0, 6'd0);
        for (int ln = 0; ln < 8; ln++) begin
            for (int i = 0; i < 10; i++) pix[i] = 16'(ln * 256 + i * 7 + 1);
            send_line(1, 10, 1'b0);
        end
        end_frame();
        check("ovf_flag", ovf_s, 1);
        check("ovf_done", done_s, 1);
        check("ovf_word_cnt", word_cnt_s, 16);
        check("ovf_last_addr", last_addr_s, 4'hF);
        check("ovf_addr_hold", wr_addr_s, 4'hF);
        check("ovf_q_empty", exp_q_s.size(), 0);
        check("ovf_big_idle", busy, 0);
        cap_req_s = 1'b0;
        cyc(4);

        // abort: request dropped mid-line
        start_frame(0, 2'd2, 6'd32);
        for (int i = 0; i < 4; i++) drive_pixel(16'h07E0);
        cap_req = 1'b0;
        cyc(3);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 6; i++) drive_pixel(16'h07E0);
        @(negedge PCLK);
        HREF = 1'b0;
        cyc(4);
        end_frame();
        check("abort_done_end", done, 0);
        check("abort_word_cnt", word_cnt, 0);

        // reset mid-line, then recapture only after a fresh VSYNC cycle
        start_frame(0, 2'd0, 6'd0);
        drive_pixel(16'h1111);
        drive_pixel(16'h2222);
        push_word(0, 32'h22221111);
        drive_pixel(16'h3333);
        #1 HRESETn = 1'b0;
        #1;
        check("rr_wr_en", wr_en, 0);
        check("rr_wr_addr", wr_addr, 0);
        check("rr_word_cnt", word_cnt, 0);
        check("rr_wr_data", wr_data, 0);
        check("rr_busy", busy, 0);
        check("rr_q_empty", exp_q.size(), 0);
        cyc(2);
        HRESETn = 1'b1;
        HREF = 1'b0;
        cyc(4);
        for (int i = 0; i < 4; i++) pix[i] = 16'h4444;
        send_line(2, 4, 1'b0);
        check("rr_no_capture_busy", busy, 0);
        check("rr_no_capture_cnt", word_cnt, 0);
        start_frame(0, 2'd0, 6'd0);
        pix[0] = 16'hAAAA; pix[1] = 16'hBBBB;
        send_line(0, 2, 1'b0);
        end_frame();
        check("rr_word_cnt_end", word_cnt, 1);
        check("rr_done", done, 1);
        check("rr_q_empty_end", exp_q.size(), 0);
        cap_req = 1'b0;
        cyc(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
